// File: rtl/packet_tx_scheduler_if.sv
// rtl/packet_tx_scheduler_if.sv - requester and serializer signal bundle for packet_tx_scheduler
interface packet_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*56-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic                  err;
    logic                  busy;
    logic [2:0]            grant_id;
    logic                  tx_enable;
    logic [63:0]           tx_data;
    logic                  tx_packet_done;

    // Requesters and the serializer side drive the inputs of the scheduler.
    modport master (
        output req, req_data, tx_packet_done,
        input  ack, err, busy, grant_id, tx_enable, tx_data
    );

    // The scheduler itself.
    modport slave (
        input  req, req_data, tx_packet_done,
        output ack, err, busy, grant_id, tx_enable, tx_data
    );
endinterface

// File: rtl/packet_tx_scheduler.sv
// rtl/packet_tx_scheduler.sv - round-robin packet scheduler with serial CRC-8 in front of transmit_control
module packet_tx_scheduler #(
    parameter int          NUM_REQ        = 4,
    parameter logic [7:0]  CRC_POLY       = 8'h07,
    parameter logic [7:0]  CRC_INIT       = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input logic                  clk,
    input logic                  rst,
    packet_tx_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Value of the WAIT counter on the last cycle before a timeout abort.
    localparam logic [31:0] LP_TMO_LAST  = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LP_LAST_INIT = 3'(NUM_REQ - 1);

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_last;
    logic [2:0]         r_grant_id;
    logic [55:0]        r_pay;
    logic [7:0]         r_crc;
    logic [5:0]         r_bitcnt;
    logic [31:0]        r_wait_cnt;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_err;
    logic               r_tx_enable;
    logic [63:0]        r_tx_data;

    logic               w_found;
    logic [2:0]         w_winner;
    int                 w_idx;
    logic               w_timeout;
    logic               w_fb;
    logic [7:0]         w_crc_next;

    // Round-robin search: first pending request after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
    end

    // One CRC-8 step on the current payload bit, MSB first.
    always_comb begin
        w_fb       = r_crc[7] ^ r_pay[r_bitcnt];
        w_crc_next = {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; the timeout only applies while waiting on the serializer.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:   if (w_found) w_next = S_CALC;
            S_CALC:   if (r_bitcnt == 6'd0) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.tx_packet_done) begin
                    w_next = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (r_wait_cnt == LP_TMO_LAST)) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= LP_LAST_INIT;
            r_grant_id  <= 3'd0;
            r_pay       <= 56'd0;
            r_crc       <= 8'd0;
            r_bitcnt    <= 6'd0;
            r_wait_cnt  <= 32'd0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_tx_enable <= 1'b0;
            r_tx_data   <= 64'd0;
        end else begin
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_tx_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_winner;
                        r_last     <= w_winner;
                        r_pay      <= bus.req_data[56*w_winner +: 56];
                        r_crc      <= CRC_INIT;
                        r_bitcnt   <= 6'd55;
                    end
                end
                S_CALC: begin
                    r_crc    <= w_crc_next;
                    r_bitcnt <= r_bitcnt - 6'd1;
                end
                S_LAUNCH: begin
                    r_tx_data   <= {r_pay, r_crc};
                    r_tx_enable <= 1'b1;
                    r_wait_cnt  <= 32'd0;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 32'd1;
                    r_err      <= w_timeout;
                end
                S_DONE: begin
                    r_ack <= NUM_REQ'(1) << r_grant_id;
                end
                default: begin
                    r_ack <= '0;
                end
            endcase
        end
    end

    assign bus.ack       = r_ack;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.grant_id  = r_grant_id;
    assign bus.tx_enable = r_tx_enable;
    assign bus.tx_data   = r_tx_data;
endmodule

// File: tb/tb_packet_tx_scheduler.sv
// tb/tb_packet_tx_scheduler.sv - self-checking bench for packet_tx_scheduler
module tb_packet_tx_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    packet_tx_scheduler_if #(.NUM_REQ(4)) bus ();
    packet_tx_scheduler_if #(.NUM_REQ(4)) bus2 ();

    packet_tx_scheduler #(
        .NUM_REQ(4), .CRC_POLY(8'h07), .CRC_INIT(8'h00), .TIMEOUT_CYCLES(2_000_000)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    packet_tx_scheduler #(
        .NUM_REQ(4), .CRC_POLY(8'h07), .CRC_INIT(8'h00), .TIMEOUT_CYCLES(50)
    ) dut_to (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // Reference CRC-8 (poly 0x07, init 0), computed byte-wise over the 7 payload bytes.
    function automatic logic [7:0] crc8(input logic [55:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 6; b >= 0; b--) begin
            c = c ^ p[b*8 +: 8];
            for (int j = 0; j < 8; j++) begin
                if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
                else      c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Reference round-robin choice.
    function automatic int rr_pick(input logic [3:0] m, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (m[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [55:0] rnd56();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[55:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Observe: steps until tx_enable is seen (bounded); lat=-1 on expiry.
    task automatic wait_launch(input bit b2, output int lat, output logic [2:0] gid, output logic [63:0] data);
        lat  = -1;
        gid  = 3'd0;
        data = 64'd0;
        for (int n = 1; n <= 300; n++) begin
            step();
            if (b2 ? bus2.tx_enable : bus.tx_enable) begin
                lat  = n;
                gid  = b2 ? bus2.grant_id : bus.grant_id;
                data = b2 ? bus2.tx_data : bus.tx_data;
                break;
            end
        end
    endtask

    // Stimulus: wait dly cycles, pulse tx_packet_done, observe ack before and at its slot.
    task automatic complete(input bit b2, input int dly, output logic [3:0] ack_early,
                            output logic [3:0] ack_obs, output logic busy_obs, output logic [63:0] data_pre);
        repeat (dly) step();
        data_pre = b2 ? bus2.tx_data : bus.tx_data;
        if (b2) bus2.tx_packet_done = 1'b1; else bus.tx_packet_done = 1'b1;
        step();
        if (b2) bus2.tx_packet_done = 1'b0; else bus.tx_packet_done = 1'b0;
        ack_early = b2 ? bus2.ack : bus.ack;
        step();
        ack_obs  = b2 ? bus2.ack : bus.ack;
        busy_obs = b2 ? bus2.busy : bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", bus.grant_id); end
        checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL reset_tx_enable got %b want 0", bus.tx_enable); end
        checks++; if (bus.tx_data !== 64'd0) begin errors++; $display("FAIL reset_tx_data got %h want 0", bus.tx_data); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_known_vectors();
        logic [55:0] pays [3];
        logic [63:0] exps [3];
        int lat; logic [2:0] gid; logic [63:0] data, pre; logic [3:0] ae, ao; logic bo;
        pays[0] = 56'h00000000000001; exps[0] = 64'h0000000000000107;
        pays[1] = 56'h00000000000080; exps[1] = 64'h0000000000008089;
        pays[2] = 56'h00000000000000; exps[2] = 64'h0000000000000000;
        for (int i = 0; i < 3; i++) begin
            bus.req_data[55:0] = pays[i];
            bus.req = 4'b0001;
            wait_launch(0, lat, gid, data);
            checks++; if (lat !== 58) begin errors++; $display("FAIL known%0d_latency got %0d want 58", i, lat); end
            checks++; if (gid !== 3'd0) begin errors++; $display("FAIL known%0d_grant got %0d want 0", i, gid); end
            checks++; if (data !== exps[i]) begin errors++; $display("FAIL known%0d_tx_data got %h want %h", i, data, exps[i]); end
            step();
            checks++; if (bus.tx_enable !== 1'b0) begin errors++; $display("FAIL known%0d_enable_width got %b want 0", i, bus.tx_enable); end
            complete(0, 99, ae, ao, bo, pre);
            checks++; if (ae !== 4'b0) begin errors++; $display("FAIL known%0d_ack_early got %b want 0000", i, ae); end
            checks++; if (ao !== 4'b0001) begin errors++; $display("FAIL known%0d_ack got %b want 0001", i, ao); end
            checks++; if (bo !== 1'b0) begin errors++; $display("FAIL known%0d_busy_after got %b want 0", i, bo); end
            bus.req = 4'b0000;
            step();
            checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL known%0d_ack_width got %b want 0000", i, bus.ack); end
        end
    endtask

    task automatic test_all_req();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [55:0] d [4];
        int lat; logic [2:0] gid; logic [63:0] data, pre; logic [3:0] ae, ao; logic bo;
        reset_pulse();
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) begin
                d[i] = rnd56();
                bus.req_data[56*i +: 56] = d[i];
            end
            wait_launch(0, lat, gid, data);
            checks++; if (lat !== 58) begin errors++; $display("FAIL rr%0d_latency got %0d want 58", n, lat); end
            checks++; if (gid !== 3'(order[n])) begin errors++; $display("FAIL rr%0d_grant got %0d want %0d", n, gid, order[n]); end
            checks++; if (data !== {d[order[n]], crc8(d[order[n]])}) begin errors++; $display("FAIL rr%0d_tx_data got %h want %h", n, data, {d[order[n]], crc8(d[order[n]])}); end
            complete(0, $urandom_range(2, 40), ae, ao, bo, pre);
            checks++; if (pre !== data) begin errors++; $display("FAIL rr%0d_tx_data_stable got %h want %h", n, pre, data); end
            checks++; if (ao !== (4'b0001 << order[n])) begin errors++; $display("FAIL rr%0d_ack got %b want %b", n, ao, 4'b0001 << order[n]); end
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_capture();
        logic [55:0] d_orig;
        int lat; logic [2:0] gid; logic [63:0] data, pre; logic [3:0] ae, ao; logic bo;
        d_orig = rnd56();
        bus.req_data[56 +: 56] = d_orig;
        bus.req = 4'b0010;
        repeat (10) step();
        bus.req_data[56 +: 56] = ~d_orig;
        wait_launch(0, lat, gid, data);
        checks++; if (lat !== 48) begin errors++; $display("FAIL capture_latency got %0d want 48", lat); end
        checks++; if (data !== {d_orig, crc8(d_orig)}) begin errors++; $display("FAIL capture_tx_data got %h want %h", data, {d_orig, crc8(d_orig)}); end
        step();
        bus.req = 4'b0000;
        bus.req_data[56 +: 56] = rnd56();
        complete(0, 20, ae, ao, bo, pre);
        checks++; if (ao !== 4'b0010) begin errors++; $display("FAIL capture_ack got %b want 0010", ao); end
        checks++; if (pre !== {d_orig, crc8(d_orig)}) begin errors++; $display("FAIL capture_tx_data_hold got %h want %h", pre, {d_orig, crc8(d_orig)}); end
    endtask

    task automatic test_timeout();
        logic [55:0] d0, d1;
        int lat, n; logic saw_ack; logic [2:0] gid; logic [63:0] data, pre; logic [3:0] ae, ao; logic bo;
        d0 = rnd56();
        d1 = rnd56();
        bus2.req_data[55:0]  = d0;
        bus2.req_data[111:56] = d1;
        bus2.req = 4'b0011;
        wait_launch(1, lat, gid, data);
        checks++; if (lat !== 58 || gid !== 3'd0) begin errors++; $display("FAIL timeout_first_launch got lat %0d id %0d want 58 0", lat, gid); end
        n = -1;
        saw_ack = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (bus2.ack !== 4'b0) saw_ack = 1'b1;
            if (bus2.err) begin
                n = k;
                break;
            end
        end
        checks++; if (n !== 50) begin errors++; $display("FAIL timeout_err_cycle got %0d want 50", n); end
        checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL timeout_no_ack got %b want 0", saw_ack); end
        checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", bus2.busy); end
        step();
        checks++; if (bus2.err !== 1'b0) begin errors++; $display("FAIL timeout_err_width got %b want 0", bus2.err); end
        wait_launch(1, lat, gid, data);
        checks++; if (lat !== 57 || gid !== 3'd1) begin errors++; $display("FAIL timeout_next_grant got lat %0d id %0d want 57 1", lat, gid); end
        checks++; if (data !== {d1, crc8(d1)}) begin errors++; $display("FAIL timeout_next_data got %h want %h", data, {d1, crc8(d1)}); end
        complete(1, 30, ae, ao, bo, pre);
        checks++; if (ao !== 4'b0010) begin errors++; $display("FAIL timeout_next_ack got %b want 0010", ao); end
        bus2.req = 4'b0001;
        wait_launch(1, lat, gid, data);
        checks++; if (gid !== 3'd0 || data !== {d0, crc8(d0)}) begin errors++; $display("FAIL timeout_retry got id %0d data %h want 0 %h", gid, data, {d0, crc8(d0)}); end
        complete(1, 10, ae, ao, bo, pre);
        checks++; if (ao !== 4'b0001) begin errors++; $display("FAIL timeout_retry_ack got %b want 0001", ao); end
        bus2.req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        logic [55:0] d, d2;
        int lat; logic [2:0] gid; logic [63:0] data, pre; logic [3:0] ae, ao; logic bo;
        d  = rnd56() | 56'h1;
        d2 = rnd56();
        bus.req_data[55:0] = d;
        bus.req = 4'b0001;
        repeat (20) step();
        #3 rst = 1'b1;
        #1;
        checks++; if ({bus.ack, bus.err, bus.busy, bus.grant_id, bus.tx_enable, bus.tx_data} !== 74'd0) begin
            errors++; $display("FAIL rst_in_calc got busy %b id %0d data %h want all 0", bus.busy, bus.grant_id, bus.tx_data); end
        @(posedge clk);
        #1 rst = 1'b0;
        wait_launch(0, lat, gid, data);
        checks++; if (lat !== 58 || data !== {d, crc8(d)}) begin errors++; $display("FAIL rst_relaunch got lat %0d data %h want 58 %h", lat, data, {d, crc8(d)}); end
        repeat (5) step();
        #3 rst = 1'b1;
        #1;
        checks++; if ({bus.ack, bus.err, bus.busy, bus.grant_id, bus.tx_enable, bus.tx_data} !== 74'd0) begin
            errors++; $display("FAIL rst_in_wait got busy %b id %0d data %h want all 0", bus.busy, bus.grant_id, bus.tx_data); end
        @(posedge clk);
        #1;
        bus.req = 4'b0000;
        rst = 1'b0;
        bus.tx_packet_done = 1'b1;
        step();
        bus.tx_packet_done = 1'b0;
        step();
        checks++; if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL stray_done got ack %b busy %b want 0000 0", bus.ack, bus.busy); end
        bus.req_data[111:56] = d2;
        bus.req = 4'b0010;
        wait_launch(0, lat, gid, data);
        checks++; if (lat !== 58 || gid !== 3'd1) begin errors++; $display("FAIL post_rst_grant got lat %0d id %0d want 58 1", lat, gid); end
        complete(0, 15, ae, ao, bo, pre);
        checks++; if (ao !== 4'b0010) begin errors++; $display("FAIL post_rst_ack got %b want 0010", ao); end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_random();
        logic [55:0] d [4];
        logic [3:0] m;
        int last, w;
        int lat; logic [2:0] gid; logic [63:0] data, pre; logic [3:0] ae, ao; logic bo;
        reset_pulse();
        last = 3;
        for (int it = 0; it < 12; it++) begin
            m = bus.req | 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) m = 4'($urandom_range(0, 15));
            if (m == 4'b0) m = 4'b0001 << $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                d[i] = rnd56();
                bus.req_data[56*i +: 56] = d[i];
            end
            bus.req = m;
            w = rr_pick(m, last);
            wait_launch(0, lat, gid, data);
            checks++; if (lat !== 58) begin errors++; $display("FAIL rand%0d_latency got %0d want 58", it, lat); end
            checks++; if (gid !== 3'(w)) begin errors++; $display("FAIL rand%0d_grant got %0d want %0d (req %b)", it, gid, w, m); end
            checks++; if (data !== {d[w], crc8(d[w])}) begin errors++; $display("FAIL rand%0d_tx_data got %h want %h", it, data, {d[w], crc8(d[w])}); end
            for (int i = 0; i < 4; i++) bus.req_data[56*i +: 56] = rnd56();
            complete(0, $urandom_range(1, 40), ae, ao, bo, pre);
            checks++; if (ae !== 4'b0) begin errors++; $display("FAIL rand%0d_ack_early got %b want 0000", it, ae); end
            checks++; if (ao !== (4'b0001 << w)) begin errors++; $display("FAIL rand%0d_ack got %b want %b", it, ao, 4'b0001 << w); end
            bus.req[w] = 1'b0;
            last = w;
        end
        bus.req = 4'b0000;
        step();
    endtask

    // Continuous property: at most one ack bit, and never ack together with err.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if ($countones(bus.ack) > 1 || (bus.ack !== 4'b0 && bus.err === 1'b1)) begin
                errors++;
                $display("FAIL ack_exclusive got ack %b err %b want onehot0 and not both", bus.ack, bus.err);
            end
            if ($countones(bus2.ack) > 1 || (bus2.ack !== 4'b0 && bus2.err === 1'b1)) begin
                errors++;
                $display("FAIL ack_exclusive_to got ack %b err %b want onehot0 and not both", bus2.ack, bus2.err);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req = 4'b0;  bus.req_data = '0;  bus.tx_packet_done = 1'b0;
        bus2.req = 4'b0; bus2.req_data = '0; bus2.tx_packet_done = 1'b0;
        test_reset();
        test_known_vectors();
        test_all_req();
        test_capture();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/packet_tx_scheduler.md
# packet_tx_scheduler

Shares one `transmit_control` packet serializer between `NUM_REQ` requesters. It arbitrates round-robin, captures the winner's 56-bit header/payload and computes a serial CRC-8 over it. It then presents the 64-bit packet (payload in bits 63:8, CRC in bits 7:0), launches the serializer with a one-cycle enable, and acknowledges the requester when the serializer reports `packet_done`. It sits between the packet sources and `transmit_control` in the CRC64 config/control path.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CRC_POLY`, 8'h07: CRC-8 polynomial, implicit x^8.
- `CRC_INIT`, 8'h00: CRC register start value.
- `TIMEOUT_CYCLES`, 2_000_000: maximum WAIT cycles before abort; 0 disables the timeout; 32-bit counter.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  level request, one bit per requester.
- `req_data`  in  NUM_REQ*56  requester i payload at bits [56*i+55 : 56*i].
- `ack`  out  NUM_REQ  one-cycle pulse to the served requester on completion.
- `err`  out  1  one-cycle pulse on timeout abort.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  3  index of the current or last granted requester.
- `tx_enable`  out  1  to serializer `enable`; one-cycle pulse.
- `tx_data`  out  64  to serializer `data_in`.
- `tx_packet_done`  in  1  from serializer `packet_done`; one-cycle pulse.

## Operation
- Reset values: `ack`=0, `err`=0, `busy`=0, `grant_id`=0, `tx_enable`=0, `tx_data`=0. State is IDLE and the round-robin pointer `last`=NUM_REQ-1, so requester 0 has first priority.
- State machine: IDLE -> CALC -> LAUNCH -> WAIT -> DONE -> IDLE.
- IDLE: if any `req` bit is high, grant the first set bit scanning `last+1`, `last+2`, ... modulo NUM_REQ.
  - On grant: `grant_id` <= winner, `last` <= winner, capture the winner's 56-bit slice into `pay`, `crc` <= CRC_INIT, bit counter <= 55, go to CALC.
  - If no `req` bit is high, stay in IDLE.
- CALC: 56 cycles, one bit per cycle, MSB first (pay[55] down to pay[0]).
  - Per cycle: fb = crc[7] ^ bit; crc <= {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - After the bit-0 cycle, go to LAUNCH.
- LAUNCH: `tx_data` <= {pay, crc}, `tx_enable` <= 1 for exactly one cycle, go to WAIT.
  - `tx_data` holds this value until the next LAUNCH; the serializer samples it over the whole packet.
- WAIT: on `tx_packet_done`=1, go to DONE.
  - If TIMEOUT_CYCLES≠0 and the WAIT cycle count reaches TIMEOUT_CYCLES, pulse `err` for one cycle, pulse no `ack`, and go to IDLE.
  - After a timeout the requester's `req` is still pending, so it is retried on its next round-robin turn.
- DONE: `ack[grant_id]` = 1 for one cycle, go to IDLE.
- Requester rules:
  - Hold `req` until `ack`.
  - `req_data` is captured at grant; later changes are ignored.
  - Dropping `req` before grant withdraws the request.
  - Dropping `req` after grant does not cancel the packet, and `ack` still pulses.
- `tx_packet_done` outside WAIT is ignored.
- `req` changes while `busy` are ignored until the next IDLE.
- Reset mid-operation: all outputs immediately return to their reset values and no `ack` is issued. The serializer must be reset alongside.

## Timing
- Grant sampled at rising edge E0. CALC occupies cycles E0+1..E0+56. `tx_enable` is high in the cycle after edge E0+57, i.e. launch latency is 57 cycles.
- `ack` is high in the cycle after the edge following the edge that samples `tx_packet_done`: done sampled at Ed, DONE state at Ed+1, `ack` high during that cycle.
- Back-to-back service: after DONE, IDLE can grant on the next edge. Minimum spacing between launches is 60 cycles plus serializer time.
- Only one `ack` bit is ever high in a cycle. `ack` and `err` are never high in the same cycle.

## Test plan
- Single request, req_data[55:0]=56'h00000000000001 on req[0] -> after 57 cycles `tx_enable` pulses once with `tx_data`=64'h0000000000000107; model `tx_packet_done` 100 cycles later -> `ack`=4'b0001 one cycle later, `busy` falls.
- req[0] payload 56'h00000000000080 -> `tx_data`=64'h0000000000008089. All-zero payload -> `tx_data`=64'h0.
- `req`=4'b1111 held, each acked as served -> grant order 0,1,2,3,0; each `ack` matches `grant_id`; `tx_data` stable between launches.
- Change req_data for the granted requester during CALC, and drop its `req` during WAIT -> original data is transmitted and `ack` still pulses.
- TIMEOUT_CYCLES=50, never assert `tx_packet_done` -> `err` pulses in WAIT cycle 50, no `ack`, next grant goes to the next requester in turn, and the timed-out requester is served later.
- Assert `rst` during CALC and again during WAIT -> all outputs 0 asynchronously; after release `req`=4'b0010 is granted with full 57-cycle latency; a stray `tx_packet_done` in IDLE produces no `ack`.
